// File: rtl/hsv_core_commit_sink.sv
// Commit sink: writeback, retire counting, and trap/jump resolution via flush handshake then fetch redirect.
package hsv_core_commit_sink_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
  } commit_common_t;

  typedef struct packed {
    commit_common_t common;
    logic [31:0]    result;
    logic [31:0]    next_pc;
    logic           jump;
    logic           trap;
    logic           writeback;
  } commit_data_t;
endpackage

module hsv_core_commit_sink
  import hsv_core_commit_sink_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          RETIRE_WIDTH = 64
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  commit_data_t            commit_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    flush_req,
  input  logic                    flush_ack,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd,
  output logic [31:0]             wb_data,
  output logic                    redirect_valid,
  output logic [31:0]             redirect_pc,
  input  logic                    redirect_ready,
  output logic                    trap_valid,
  output logic [31:0]             trap_pc,
  output logic [RETIRE_WIDTH-1:0] retired
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    flush_req_q, flush_req_d;
  logic                    redirect_valid_q, redirect_valid_d;
  logic [31:0]             redirect_pc_q, redirect_pc_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [4:0]              wb_rd_q, wb_rd_d;
  logic [31:0]             wb_data_q, wb_data_d;
  logic                    trap_valid_q, trap_valid_d;
  logic [31:0]             trap_pc_q, trap_pc_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;

  logic accept;
  logic eff_trap;

  assign in_ready = (state_q == ST_RUN);
  assign accept   = in_valid && in_ready;
  // A jump to a non-word-aligned target is resolved exactly like a trap.
  assign eff_trap = commit_data.trap ||
                    (commit_data.jump && (commit_data.next_pc[1:0] != 2'b00));

  always_comb begin
    state_d          = state_q;
    flush_req_d      = flush_req_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    wb_valid_d       = 1'b0;
    wb_rd_d          = 5'd0;
    wb_data_d        = 32'd0;
    trap_valid_d     = 1'b0;
    trap_pc_d        = 32'd0;
    retired_d        = retired_q;

    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (eff_trap) begin
            trap_valid_d  = 1'b1;
            trap_pc_d     = commit_data.common.pc;
            state_d       = ST_FLUSH;
            flush_req_d   = 1'b1;
            redirect_pc_d = TRAP_VECTOR;
          end else begin
            if (commit_data.writeback && (commit_data.common.rd != 5'd0)) begin
              wb_valid_d = 1'b1;
              wb_rd_d    = commit_data.common.rd;
              wb_data_d  = commit_data.result;
            end
            retired_d = retired_q + RETIRE_WIDTH'(1);
            if (commit_data.jump) begin
              state_d       = ST_FLUSH;
              flush_req_d   = 1'b1;
              redirect_pc_d = commit_data.next_pc;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (flush_ack) begin
          state_d          = ST_REDIRECT;
          flush_req_d      = 1'b0;
          redirect_valid_d = 1'b1;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d          = ST_RUN;
          redirect_valid_d = 1'b0;
        end
      end
      default: begin
        state_d          = ST_RUN;
        flush_req_d      = 1'b0;
        redirect_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q          <= ST_RUN;
      flush_req_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      wb_valid_q       <= 1'b0;
      wb_rd_q          <= 5'd0;
      wb_data_q        <= 32'd0;
      trap_valid_q     <= 1'b0;
      trap_pc_q        <= 32'd0;
      retired_q        <= '0;
    end else begin
      state_q          <= state_d;
      flush_req_q      <= flush_req_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      wb_valid_q       <= wb_valid_d;
      wb_rd_q          <= wb_rd_d;
      wb_data_q        <= wb_data_d;
      trap_valid_q     <= trap_valid_d;
      trap_pc_q        <= trap_pc_d;
      retired_q        <= retired_d;
    end
  end

  assign flush_req      = flush_req_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign trap_valid     = trap_valid_q;
  assign trap_pc        = trap_pc_q;
  assign retired        = retired_q;

endmodule
